// File: rtl/sp_usb_word_bridge_if.sv
// Signal bundle between the USB FIFO synchronizer, the word bridge and the kernel stream fabric.
// The master modport is the bridge's own view; slave is the view of everything around it.
interface sp_usb_word_bridge_if #(
    parameter int WIDTH = 32
);
    logic [7:0]       usb_dout;
    logic             usb_avail;
    logic             usb_read;
    logic [7:0]       usb_din;
    logic             usb_write;
    logic             usb_wr_ready;
    logic [WIDTH-1:0] from_usb_data;
    logic             from_usb_valid;
    logic             from_usb_ready;
    logic [WIDTH-1:0] to_usb_data;
    logic             to_usb_valid;
    logic             to_usb_ready;

    modport master (
        input  usb_dout, usb_avail, usb_wr_ready, from_usb_ready, to_usb_data, to_usb_valid,
        output usb_read, usb_din, usb_write, from_usb_data, from_usb_valid, to_usb_ready
    );

    modport slave (
        output usb_dout, usb_avail, usb_wr_ready, from_usb_ready, to_usb_data, to_usb_valid,
        input  usb_read, usb_din, usb_write, from_usb_data, from_usb_valid, to_usb_ready
    );
endinterface

// File: rtl/sp_usb_word_bridge.sv
// Bridges the 8-bit USB FIFO byte port to WIDTH-bit valid/ready word streams in both directions.
// Byte 0 of a word (bits [7:0]) is always first on the wire.
module sp_usb_word_bridge #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    sp_usb_word_bridge_if.master  bus
);
    localparam int BYTES = WIDTH / 8;
    localparam int CW    = $clog2(BYTES) + 1;

    logic [CW-1:0]    rx_count_q, rx_count_d;
    logic [WIDTH-1:0] from_usb_data_q, from_usb_data_d;
    logic             from_usb_valid_q, from_usb_valid_d;
    logic             usb_read_q, usb_read_d;
    logic [CW-1:0]    tx_count_q, tx_count_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             tx_busy_q, tx_busy_d;
    logic [7:0]       usb_din_q, usb_din_d;
    logic             usb_write_q, usb_write_d;
    logic             rx_capture_s;
    logic             tx_accept_s;
    logic             tx_emit_s;

    // Next-state logic for both byte paths; RX packs straight into the output word register.
    always_comb begin
        rx_count_d       = rx_count_q;
        from_usb_data_d  = from_usb_data_q;
        from_usb_valid_d = from_usb_valid_q;
        usb_read_d       = 1'b0;
        tx_count_d       = tx_count_q;
        tx_data_d        = tx_data_q;
        tx_busy_d        = tx_busy_q;
        usb_din_d        = usb_din_q;
        usb_write_d      = 1'b0;

        // usb_read_q blocks a second capture while the synchronizer is still dropping avail.
        rx_capture_s = bus.usb_avail && !usb_read_q && !from_usb_valid_q;
        tx_accept_s  = bus.to_usb_valid && !tx_busy_q;
        tx_emit_s    = tx_busy_q && bus.usb_wr_ready && !usb_write_q;

        if (from_usb_valid_q && bus.from_usb_ready) begin
            from_usb_valid_d = 1'b0;
        end else begin
            from_usb_valid_d = from_usb_valid_q;
        end

        if (rx_capture_s) begin
            for (int k = 0; k < BYTES; k++) begin
                if (rx_count_q == CW'(k)) begin
                    from_usb_data_d[8*k +: 8] = bus.usb_dout;
                end else begin
                    from_usb_data_d[8*k +: 8] = from_usb_data_q[8*k +: 8];
                end
            end
            usb_read_d = 1'b1;
            if (rx_count_q == CW'(BYTES - 1)) begin
                rx_count_d       = {CW{1'b0}};
                from_usb_valid_d = 1'b1;
            end else begin
                rx_count_d = rx_count_q + CW'(1'b1);
            end
        end else begin
            rx_count_d = rx_count_q;
        end

        if (tx_accept_s) begin
            tx_data_d  = bus.to_usb_data;
            tx_busy_d  = 1'b1;
            tx_count_d = {CW{1'b0}};
        end else if (tx_emit_s) begin
            for (int k = 0; k < BYTES; k++) begin
                if (tx_count_q == CW'(k)) begin
                    usb_din_d = tx_data_q[8*k +: 8];
                end else begin
                    usb_din_d = usb_din_d;
                end
            end
            usb_write_d = 1'b1;
            if (tx_count_q == CW'(BYTES - 1)) begin
                tx_busy_d  = 1'b0;
                tx_count_d = {CW{1'b0}};
            end else begin
                tx_count_d = tx_count_q + CW'(1'b1);
            end
        end else begin
            tx_busy_d = tx_busy_q;
        end
    end

    // State registers with synchronous reset; reset discards any partial word in either direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_count_q       <= {CW{1'b0}};
            from_usb_data_q  <= {WIDTH{1'b0}};
            from_usb_valid_q <= 1'b0;
            usb_read_q       <= 1'b0;
            tx_count_q       <= {CW{1'b0}};
            tx_data_q        <= {WIDTH{1'b0}};
            tx_busy_q        <= 1'b0;
            usb_din_q        <= 8'h00;
            usb_write_q      <= 1'b0;
        end else begin
            rx_count_q       <= rx_count_d;
            from_usb_data_q  <= from_usb_data_d;
            from_usb_valid_q <= from_usb_valid_d;
            usb_read_q       <= usb_read_d;
            tx_count_q       <= tx_count_d;
            tx_data_q        <= tx_data_d;
            tx_busy_q        <= tx_busy_d;
            usb_din_q        <= usb_din_d;
            usb_write_q      <= usb_write_d;
        end
    end

    assign bus.usb_read       = usb_read_q;
    assign bus.usb_din        = usb_din_q;
    assign bus.usb_write      = usb_write_q;
    assign bus.from_usb_data  = from_usb_data_q;
    assign bus.from_usb_valid = from_usb_valid_q;
    assign bus.to_usb_ready   = !tx_busy_q;
endmodule

// File: tb/tb_sp_usb_word_bridge.sv
// Randomized bench for sp_usb_word_bridge (WIDTH=32): a byte-queue USB source/sink and a word-level
// reference model predict every received word, every transmitted byte and the ready flag.
module tb_sp_usb_word_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sp_usb_word_bridge_if #(.WIDTH(32)) bus ();
    sp_usb_word_bridge #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [7:0]  rx_src[$];
    logic [31:0] tx_src[$];
    logic [31:0] exp_words[$];
    logic [7:0]  tx_bytes[$];
    int          rx_k = 0;
    logic [31:0] rx_word = 32'h0;
    logic [7:0]  last_din = 8'h00;

    logic read_prev = 1'b0, write_prev = 1'b0, valid_prev = 1'b0, wr_ready_prev = 1'b0;
    logic rst_prev = 1'b1, tx_holding = 1'b0;
    int   p_avail = 0, p_wr = 0, p_rdy = 0, p_valid = 0;
    logic rx_hold = 1'b0, tx_hold = 1'b0;

    logic        s_rd, s_wr, s_fv, s_tr;
    logic [7:0]  s_din;
    logic [31:0] s_fd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: sample at negedge, check against the model, then drive inputs for the next edge.
    task automatic step(input logic rst_in);
        logic [7:0] b;
        logic       acc;
        @(negedge clk);
        s_rd = bus.usb_read; s_wr = bus.usb_write; s_din = bus.usb_din;
        s_fv = bus.from_usb_valid; s_fd = bus.from_usb_data; s_tr = bus.to_usb_ready;
        if (rst_prev) begin
            rx_k = 0; rx_word = 32'h0; exp_words.delete(); tx_bytes.delete(); last_din = 8'h00;
            check("rst_out", {s_rd, s_wr, s_din, s_fv, s_fd}, 64'h0);
            check("rst_rdy", s_tr, 64'h1);
        end else begin
            if (s_rd) begin
                check("rd_gap", read_prev, 64'h0);
                check("rd_bp", valid_prev, 64'h0);
                b = rx_src.pop_front();
                rx_word = rx_word | (32'(b) << (8 * rx_k));
                rx_k++;
                if (rx_k == 4) begin
                    exp_words.push_back(rx_word);
                    rx_k = 0; rx_word = 32'h0;
                end
            end
            if (s_fv) begin
                if (exp_words.size() == 0) check("rx_spur", s_fv, 64'h0);
                else check("rx_data", s_fd, exp_words[0]);
            end else if (exp_words.size() != 0) begin
                check("rx_miss", s_fv, 64'h1);
            end
            if (s_wr) begin
                check("wr_gap", write_prev, 64'h0);
                check("wr_rdy", wr_ready_prev, 64'h1);
                if (tx_bytes.size() == 0) begin
                    check("tx_spur", s_wr, 64'h0);
                end else begin
                    last_din = tx_bytes.pop_front();
                    check("tx_byte", s_din, last_din);
                end
            end else begin
                check("din_hold", s_din, last_din);
            end
            check("tx_rdy", s_tr, (tx_bytes.size() == 0) ? 64'h1 : 64'h0);
        end

        if (rx_src.size() > 0 && !(rx_hold && rx_k == 2) && $urandom_range(0, 99) < p_avail) begin
            bus.usb_avail = 1'b1; bus.usb_dout = rx_src[0];
        end else begin
            bus.usb_avail = 1'b0; bus.usb_dout = 8'($urandom);
        end
        bus.from_usb_ready = ($urandom_range(0, 99) < p_rdy);
        if (s_fv && bus.from_usb_ready && !rst_in && exp_words.size() > 0) void'(exp_words.pop_front());
        bus.usb_wr_ready = !(tx_hold && tx_bytes.size() == 2) && ($urandom_range(0, 99) < p_wr);
        if (!tx_holding && tx_src.size() > 0 && $urandom_range(0, 99) < p_valid) tx_holding = 1'b1;
        if (tx_holding) begin
            bus.to_usb_valid = 1'b1; bus.to_usb_data = tx_src[0];
            acc = s_tr && !rst_in;
            if (acc) begin
                for (int k = 0; k < 4; k++) tx_bytes.push_back(tx_src[0][8*k +: 8]);
                void'(tx_src.pop_front());
                tx_holding = 1'b0;
            end
        end else begin
            bus.to_usb_valid = 1'b0; bus.to_usb_data = $urandom;
        end
        rst = rst_in;
        read_prev = s_rd; write_prev = s_wr; valid_prev = s_fv;
        wr_ready_prev = bus.usb_wr_ready; rst_prev = rst_in;
    endtask

    task automatic set_knobs(input int a, input int w, input int r, input int v);
        p_avail = a; p_wr = w; p_rdy = r; p_valid = v;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((rx_src.size() > 0 || exp_words.size() > 0 || tx_src.size() > 0 ||
                tx_bytes.size() > 0 || tx_holding) && n < budget) begin
            step(1'b0);
            n++;
        end
        check(tag, (n < budget) ? 64'h1 : 64'h0, 64'h1);
    endtask

    initial begin
        bus.usb_avail = 1'b0; bus.usb_dout = 8'h00; bus.usb_wr_ready = 1'b0;
        bus.from_usb_ready = 1'b0; bus.to_usb_valid = 1'b0; bus.to_usb_data = 32'h0;
        step(1'b1);
        step(1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            check("idle_out", {s_rd, s_wr, s_din, s_fv, s_fd}, 64'h0);
            check("idle_rdy", s_tr, 64'h1);
        end

        // Directed words from the plan, full rate both ways.
        rx_src = '{8'h11, 8'h22, 8'h33, 8'h44};
        tx_src = '{32'hDEADBEEF};
        set_knobs(100, 100, 100, 100);
        drain("dir_drain", 60);

        // Backpressure: one word held, next byte waiting.
        rx_src = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h55, 8'h66, 8'h77, 8'h88};
        set_knobs(100, 100, 0, 0);
        for (int i = 0; i < 20; i++) step(1'b0);
        check("bp_hold", exp_words.size(), 64'h1);
        set_knobs(100, 100, 100, 0);
        drain("bp_drain", 60);

        // TX stall mid-word.
        tx_src = '{32'h01020304};
        set_knobs(0, 100, 100, 100);
        tx_hold = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b0);
        check("stall_left", tx_bytes.size(), 64'h2);
        tx_hold = 1'b0;
        drain("stall_drain", 40);

        // Random traffic with changing pressure.
        for (int i = 0; i < 400; i++) rx_src.push_back(8'($urandom));
        for (int i = 0; i < 100; i++) tx_src.push_back($urandom);
        for (int blk = 0; blk < 10; blk++) begin
            set_knobs($urandom_range(20, 100), $urandom_range(20, 100),
                      $urandom_range(10, 100), $urandom_range(20, 100));
            for (int i = 0; i < 300; i++) step(1'b0);
        end
        set_knobs(100, 100, 100, 100);
        drain("rand_drain", 3000);

        // Reset with two bytes packed and two bytes sent.
        rx_src = '{8'hE1, 8'hE2, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        tx_src = '{32'hF4F3F2F1};
        rx_hold = 1'b1; tx_hold = 1'b1;
        begin
            int n = 0;
            while (!(rx_k == 2 && tx_bytes.size() == 2) && n < 100) begin
                step(1'b0);
                n++;
            end
            check("mid_reach", (n < 100) ? 64'h1 : 64'h0, 64'h1);
        end
        rx_hold = 1'b0; tx_hold = 1'b0;
        step(1'b1);
        set_knobs(0, 100, 100, 0);
        for (int i = 0; i < 10; i++) step(1'b0);
        check("post_rst_rdy", s_tr, 64'h1);
        set_knobs(100, 100, 100, 0);
        drain("post_rst_drain", 60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
